// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Two requesters share one registered 16-bit bitwise logic unit (OR/AND/XOR/NOR).
//   Arbitration is round-robin and only one operation is in flight at a time. The result
//   is returned only to the requester that issued it.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   req{0,1}_valid/ready       request handshake; ready is combinational, high in IDLE only
//   req{0,1}_op                00 OR, 01 AND, 10 XOR, 11 NOR
//   req{0,1}_a, req{0,1}_b     operands, WIDTH bits
//   rsp{0,1}_valid/ready       response handshake, driven only for the owning requester
//   rsp_data                   shared result bus, meaningful only while a rsp*_valid is high
//   busy                       FSM is not in IDLE
//   grant{0,1}_cnt             wrapping 16-bit grant counters, present only when
//                              LU_ARB_STATS_EN is defined
module logic_unit_arbiter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
`ifdef LU_ARB_STATS_EN
    output logic [15:0]      grant0_cnt,
    output logic [15:0]      grant1_cnt,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic             owner_q;       // requester that owns the in-flight op
    logic             last_owner_q;  // most recent grantee; loses the next contention
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             idle;
    logic             gnt0, gnt1;
    logic             rsp_hs;

    assign idle = (state_q == StIdle);

    // A lone valid requester always wins; under contention the non-last owner wins.
    assign gnt0 = idle && req0_valid && (!req1_valid || last_owner_q);
    assign gnt1 = idle && req1_valid && (!req0_valid || !last_owner_q);

    // Gated by rst_n so ready is low while reset is asserted.
    assign req0_ready = gnt0 && rst_n;
    assign req1_ready = gnt1 && rst_n;

    assign rsp0_valid = (state_q == StResp) && !owner_q;
    assign rsp1_valid = (state_q == StResp) && owner_q;
    assign rsp_hs     = owner_q ? rsp1_ready : rsp0_ready;
    assign rsp_data   = rsp_data_q;
    assign busy       = !idle;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (gnt0 || gnt1) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            op_q         <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (gnt0 || gnt1) begin
                owner_q      <= gnt1;
                last_owner_q <= gnt1;
                op_q         <= gnt1 ? req1_op : req0_op;
                a_q          <= gnt1 ? req1_a  : req0_a;
                b_q          <= gnt1 ? req1_b  : req0_b;
            end
            if (state_q == StExec) begin
                unique case (op_q)
                    2'b00:   rsp_data_q <= a_q | b_q;
                    2'b01:   rsp_data_q <= a_q & b_q;
                    2'b10:   rsp_data_q <= a_q ^ b_q;
                    default: rsp_data_q <= ~(a_q | b_q);
                endcase
            end
        end
    end

`ifdef LU_ARB_STATS_EN
    logic [15:0] grant0_cnt_q, grant1_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant0_cnt_q <= '0;
            grant1_cnt_q <= '0;
        end else begin
            if (gnt0) grant0_cnt_q <= grant0_cnt_q + 16'd1;
            if (gnt1) grant1_cnt_q <= grant1_cnt_q + 16'd1;
        end
    end

    assign grant0_cnt = grant0_cnt_q;
    assign grant1_cnt = grant1_cnt_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [1:0]  req0_op;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [1:0]  req1_op;
    logic [15:0] req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready;
    logic        rsp1_valid, rsp1_ready;
    logic [15:0] rsp_data;
    logic        busy;
`ifdef LU_ARB_STATS_EN
    logic [15:0] grant0_cnt, grant1_cnt;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
`ifdef LU_ARB_STATS_EN
        .grant0_cnt (grant0_cnt),
        .grant1_cnt (grant1_cnt),
`endif
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] t5_b   [4] = '{16'hFFFF, 16'h00FF, 16'hF000, 16'h1234};
    logic [15:0] t5_exp [4] = '{16'h0F0F, 16'h000F, 16'h0000, 16'h0204};

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 16'hFFFF; req0_b = 16'h1234;
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 16'hAAAA; req1_b = 16'hFFFF;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        step(); step();

        // Reset state
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp_data", rsp_data, 16'h0000);

        // Contention at reset exit: req0 first, then req1, then req0 again
        rst_n = 1'b1; #1;
        chk("t2_g0_req0_ready", req0_ready, 1);
        chk("t2_g0_req1_ready", req1_ready, 0);
        step();
        chk("t2_exec_busy", busy, 1);
        chk("t2_exec_req0_ready", req0_ready, 0);
        chk("t2_exec_req1_ready", req1_ready, 0);
        step();
        chk("t2_rsp0_valid", rsp0_valid, 1);
        chk("t2_rsp1_valid_low", rsp1_valid, 0);
        chk("t2_rsp0_data", rsp_data, 16'h1234);
        step();
        chk("t2_g1_req1_ready", req1_ready, 1);
        chk("t2_g1_req0_ready", req0_ready, 0);
        step(); step();
        chk("t2_rsp1_valid", rsp1_valid, 1);
        chk("t2_rsp0_valid_low", rsp0_valid, 0);
        chk("t2_rsp1_data", rsp_data, 16'h5555);
        step();
        chk("t2_g2_req0_ready", req0_ready, 1);
        chk("t2_g2_req1_ready", req1_ready, 0);
        req1_valid = 1'b0;
        step();
        req0_valid = 1'b0;
        step();
        chk("t2_rsp0b_data", rsp_data, 16'h1234);
        step();
`ifdef LU_ARB_STATS_EN
        chk("t6_grant0_cnt_a", grant0_cnt, 2);
        chk("t6_grant1_cnt_a", grant1_cnt, 1);
`endif

        // Single OR op on req0
        chk("t1_idle_busy", busy, 0);
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'h00F0; req0_b = 16'h0F0F; #1;
        chk("t1_req0_ready", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        chk("t1_exec_rsp0_valid", rsp0_valid, 0);
        step();
        chk("t1_rsp0_valid", rsp0_valid, 1);
        chk("t1_rsp_data", rsp_data, 16'h0FFF);
        step();
        chk("t1_done_busy", busy, 0);
        chk("t1_done_rsp0_valid", rsp0_valid, 0);

        // NOR on req1 with response back-pressure; req0 waits, its rsp ready is ignored
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'h0001; req0_b = 16'h0002;
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 16'h0000; req1_b = 16'h0001;
        rsp1_ready = 1'b0; #1;
        chk("t3_req1_ready", req1_ready, 1);
        chk("t3_req0_ready", req0_ready, 0);
        step();
        req1_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            rsp0_ready = i[0]; #1;
            chk("t3_hold_rsp1_valid", rsp1_valid, 1);
            chk("t3_hold_rsp0_valid", rsp0_valid, 0);
            chk("t3_hold_data", rsp_data, 16'hFFFE);
            chk("t3_hold_req0_ready", req0_ready, 0);
            step();
        end
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        step();
        chk("t3_after_req0_ready", req0_ready, 1);
        step();
        // Now in EXEC for req0: reset mid-operation
        req0_valid = 1'b0;
        chk("t4_pre_busy", busy, 1);
        rst_n = 1'b0; #1;
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_rsp0_valid", rsp0_valid, 0);
        step(); step();
        chk("t4_rst_hold_rsp0_valid", rsp0_valid, 0);
        chk("t4_rst_hold_rsp1_valid", rsp1_valid, 0);
        chk("t4_rst_data", rsp_data, 16'h0000);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'h0001; req0_b = 16'h0002;
        req1_valid = 1'b1; #1;
        chk("t4_first_req0_ready", req0_ready, 1);
        chk("t4_first_req1_ready", req1_ready, 0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        chk("t4_rsp0_valid", rsp0_valid, 1);
        chk("t4_rsp_data", rsp_data, 16'h0003);
        step();

        // Back-to-back on req1 only, one op per 3 cycles
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 16'h0F0F;
        for (int i = 0; i < 4; i++) begin
            req1_b = t5_b[i]; #1;
            chk("t5_req1_ready", req1_ready, 1);
            step();
            chk("t5_exec_busy", busy, 1);
            chk("t5_exec_req1_ready", req1_ready, 0);
            step();
            chk("t5_rsp1_valid", rsp1_valid, 1);
            chk("t5_rsp_data", rsp_data, {16'h0, t5_exp[i]});
            step();
        end
        req1_valid = 1'b0; #1;
        chk("t5_end_busy", busy, 0);
`ifdef LU_ARB_STATS_EN
        chk("t6_grant0_cnt_b", grant0_cnt, 1);
        chk("t6_grant1_cnt_b", grant1_cnt, 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
